riscv_alu_dsp_offload: RTL and testbench
========================================

RISCV_ALU_DSP_OFFLOAD -- requirements
Module: riscv_alu_dsp_offload

Interface
REQ-001 Parameter ALU_OP_WIDTH, default 7, SHALL set the width of operator ports.
REQ-002 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset; asynchronous and active-high.
REQ-004 enable_i  in  1  EX offers an op the basic ALU does not support (MUL/DIV/CLIP/bit-count).
REQ-005 operator_i  in  ALU_OP_WIDTH  ALU operator of the offered op.
REQ-006 operand_a_i, operand_b_i, operand_c_i  in  32 each  source operands.
REQ-007 flush_i  in  1  abort the current op (pipeline kill).
REQ-008 ex_ready_i  in  1  EX consumes result this cycle.
REQ-009 ready_o  out  1  block idle or result available.
REQ-010 result_valid_o  out  1  result_o valid.
REQ-011 result_o  out  32  offloaded result.
REQ-012 dsp_req_o  out  1  request to the shared DSP.
REQ-013 dsp_gnt_i  in  1  DSP accepts the request.
REQ-014 dsp_op_o  out  ALU_OP_WIDTH  registered operator.
REQ-015 dsp_a_o, dsp_b_o, dsp_c_o  out  32 each  registered operands.
REQ-016 dsp_rvalid_i  in  1  DSP response valid.
REQ-017 dsp_rdata_i  in  32  DSP response data.
REQ-018 err_o  out  1  sticky protocol error flag.

Function
REQ-019 FSM states SHALL be IDLE, REQ, WAIT, DONE, DRAIN.
REQ-020 IDLE, enable_i=1, flush_i=0: capture operator/operands into dsp_* registers; go to REQ next cycle.
REQ-021 IDLE, enable_i=0 or flush_i=1: stay in IDLE; no capture.
REQ-022 dsp_req_o SHALL be 1 only in REQ.
REQ-023 dsp_op_o/dsp_a_o/b_o/c_o SHALL stay stable from capture until the op leaves WAIT or DRAIN.
REQ-024 REQ, dsp_gnt_i=1, dsp_rvalid_i=0: go to WAIT.
REQ-025 REQ, dsp_gnt_i=1, dsp_rvalid_i=1 (same cycle): register dsp_rdata_i; go to DONE.
REQ-026 REQ, dsp_gnt_i=0: stay in REQ with request held; no timeout.
REQ-027 WAIT, dsp_rvalid_i=1: register dsp_rdata_i into result_o; go to DONE.
REQ-028 DONE: result_valid_o=1, ready_o=1; ex_ready_i=1 -> IDLE, else hold DONE with result_o unchanged.
REQ-029 DONE, ex_ready_i=1 and enable_i=1: result is consumed and the new op is not accepted; EX re-presents it in IDLE.
REQ-030 ready_o SHALL be 1 in IDLE when enable_i=0, 0 in IDLE when enable_i=1, 0 in REQ/WAIT/DRAIN, 1 in DONE.
REQ-031 flush_i in REQ with dsp_gnt_i=0: drop request; go to IDLE next cycle.
REQ-032 flush_i in REQ with dsp_gnt_i=1, or flush_i in WAIT without dsp_rvalid_i: go to DRAIN.
REQ-033 flush_i in REQ with dsp_gnt_i=1 and dsp_rvalid_i=1, or in WAIT with dsp_rvalid_i=1: discard response; go to IDLE.
REQ-034 DRAIN: discard the next dsp_rvalid_i response, then go to IDLE; result_o and result_valid_o SHALL be unaffected.
REQ-035 flush_i in DONE: clear result_valid_o; go to IDLE.
REQ-036 dsp_rvalid_i=1 in IDLE or DONE, or in REQ without dsp_gnt_i: ignore it and set err_o=1; err_o clears only on reset.
REQ-037 Minimum latency, enable_i to result_valid_o: 2 cycles (capture, then REQ with gnt and rvalid in the same cycle).
REQ-038 The block SHALL do no arithmetic; result_o SHALL equal dsp_rdata_i bit-for-bit.

Reset
REQ-039 While rst=1: state=IDLE; dsp_req_o=0, result_valid_o=0, err_o=0; result_o, dsp_op_o and dsp_a/b/c_o=0.
REQ-040 Reset asserted mid-operation SHALL abandon the op immediately; a later DSP response SHALL be treated as spurious per REQ-036.

Verification
REQ-041 enable_i with a=32'h0000_0007, b=32'h0000_0006, gnt at cycle 2, rvalid+rdata=32'h2A at cycle 4, ex_ready_i=1 -> result_valid_o=1 and result_o=32'h2A at cycle 5; IDLE at cycle 6.
REQ-042 gnt and rvalid together at first REQ cycle, rdata=32'hDEAD_BEEF -> result_valid_o=1 two cycles after enable_i.
REQ-043 gnt withheld 10 cycles -> dsp_req_o held high, operands unchanged throughout, ready_o=0; then completes normally.
REQ-044 flush_i in WAIT, rvalid 3 cycles later with rdata=32'h1234 -> result_valid_o never 1, err_o=0, IDLE after the response.
REQ-045 dsp_rvalid_i pulsed in IDLE -> err_o=1 next cycle, stays 1 until rst; FSM stays IDLE.
REQ-046 rst pulsed while in WAIT -> all outputs 0 immediately; following rvalid sets err_o=1.

Source files
------------

// File: rtl/riscv_alu_dsp_offload.sv
// riscv_alu_dsp_offload: hands unsupported EX ops to a shared DSP and returns its result.
module riscv_alu_dsp_offload #(
  parameter int ALU_OP_WIDTH = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable_i,
  input  logic [ALU_OP_WIDTH-1:0] operator_i,
  input  logic [31:0]             operand_a_i,
  input  logic [31:0]             operand_b_i,
  input  logic [31:0]             operand_c_i,
  input  logic                    flush_i,
  input  logic                    ex_ready_i,
  output logic                    ready_o,
  output logic                    result_valid_o,
  output logic [31:0]             result_o,
  output logic                    dsp_req_o,
  input  logic                    dsp_gnt_i,
  output logic [ALU_OP_WIDTH-1:0] dsp_op_o,
  output logic [31:0]             dsp_a_o,
  output logic [31:0]             dsp_b_o,
  output logic [31:0]             dsp_c_o,
  input  logic                    dsp_rvalid_i,
  input  logic [31:0]             dsp_rdata_i,
  output logic                    err_o
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} state_t;
  state_t state;
  logic spurious;
  assign dsp_req_o      = state == REQ;
  assign result_valid_o = state == DONE;
  assign ready_o        = state == IDLE ? !enable_i : state == DONE;
  // A response is only expected while granted (REQ+gnt), in WAIT, or being drained.
  assign spurious = dsp_rvalid_i && (state == IDLE || state == DONE || (state == REQ && !dsp_gnt_i));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      result_o <= '0;
      dsp_op_o <= '0;
      dsp_a_o  <= '0;
      dsp_b_o  <= '0;
      dsp_c_o  <= '0;
      err_o    <= 1'b0;
    end else begin
      if (spurious) err_o <= 1'b1;
      case (state)
        IDLE: if (enable_i && !flush_i) begin
          dsp_op_o <= operator_i;
          dsp_a_o  <= operand_a_i;
          dsp_b_o  <= operand_b_i;
          dsp_c_o  <= operand_c_i;
          state    <= REQ;
        end
        REQ: if (dsp_gnt_i) begin
          if (flush_i) state <= dsp_rvalid_i ? IDLE : DRAIN;
          else if (dsp_rvalid_i) begin
            result_o <= dsp_rdata_i;
            state    <= DONE;
          end else state <= WAIT;
        end else if (flush_i) state <= IDLE;
        WAIT: if (flush_i) state <= dsp_rvalid_i ? IDLE : DRAIN;
          else if (dsp_rvalid_i) begin
            result_o <= dsp_rdata_i;
            state    <= DONE;
          end
        DONE: if (flush_i || ex_ready_i) state <= IDLE;
        DRAIN: if (dsp_rvalid_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_riscv_alu_dsp_offload.sv
// tb_riscv_alu_dsp_offload: directed vector table plus hand sequences for flush, hold, error and reset.
module tb_riscv_alu_dsp_offload;
  localparam int W = 7;
  logic clk = 0, rst = 1, enable_i = 0, flush_i = 0, ex_ready_i = 0, dsp_gnt_i = 0, dsp_rvalid_i = 0;
  logic [W-1:0] operator_i = '0;
  logic [31:0] operand_a_i = '0, operand_b_i = '0, operand_c_i = '0, dsp_rdata_i = '0;
  logic ready_o, result_valid_o, dsp_req_o, err_o;
  logic [31:0] result_o, dsp_a_o, dsp_b_o, dsp_c_o;
  logic [W-1:0] dsp_op_o;
  int checks = 0, errors = 0;

  riscv_alu_dsp_offload #(.ALU_OP_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .enable_i(enable_i), .operator_i(operator_i),
    .operand_a_i(operand_a_i), .operand_b_i(operand_b_i), .operand_c_i(operand_c_i),
    .flush_i(flush_i), .ex_ready_i(ex_ready_i), .ready_o(ready_o),
    .result_valid_o(result_valid_o), .result_o(result_o), .dsp_req_o(dsp_req_o),
    .dsp_gnt_i(dsp_gnt_i), .dsp_op_o(dsp_op_o), .dsp_a_o(dsp_a_o), .dsp_b_o(dsp_b_o),
    .dsp_c_o(dsp_c_o), .dsp_rvalid_i(dsp_rvalid_i), .dsp_rdata_i(dsp_rdata_i), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] op;
    logic [31:0] a, b, c;
    int g, d;
    logic [31:0] rdata, exp;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [W-1:0] op, input logic [31:0] a, b, c);
    enable_i = 1; operator_i = op; operand_a_i = a; operand_b_i = b; operand_c_i = c;
    #1;
    chk("ready_idle_en", ready_o, 0);
    tick;
    enable_i = 0;
    chk("req_up", dsp_req_o, 1);
    chk("cap_op", dsp_op_o, op);
    chk("cap_a", dsp_a_o, a);
    chk("cap_b", dsp_b_o, b);
    chk("cap_c", dsp_c_o, c);
  endtask

  task automatic run(input vec_t v);
    start(v.op, v.a, v.b, v.c);
    dsp_gnt_i = 0;
    for (int i = 0; i < v.g; i++) begin
      tick;
      chk("req_hold", dsp_req_o, 1);
      chk("req_a_stable", dsp_a_o, v.a);
      chk("req_c_stable", dsp_c_o, v.c);
      chk("req_ready", ready_o, 0);
    end
    dsp_gnt_i = 1;
    if (v.d == 0) begin dsp_rvalid_i = 1; dsp_rdata_i = v.rdata; end
    tick;
    dsp_gnt_i = 0; dsp_rvalid_i = 0;
    for (int i = 0; i < v.d; i++) begin
      chk("wait_valid", result_valid_o, 0);
      chk("wait_req", dsp_req_o, 0);
      chk("wait_b_stable", dsp_b_o, v.b);
      if (i == v.d - 1) begin dsp_rvalid_i = 1; dsp_rdata_i = v.rdata; end
      tick;
    end
    dsp_rvalid_i = 0;
    chk("done_valid", result_valid_o, 1);
    chk("done_result", result_o, v.exp);
    chk("done_ready", ready_o, 1);
    chk("done_err", err_o, 0);
    ex_ready_i = 1;
    tick;
    ex_ready_i = 0;
    chk("idle_valid", result_valid_o, 0);
    chk("idle_ready", ready_o, 1);
  endtask

  initial begin
    vecs[0] = '{op: 7'h01, a: 32'h7, b: 32'h6, c: 32'h0, g: 0, d: 2, rdata: 32'h2A, exp: 32'h2A};
    vecs[1] = '{op: 7'h02, a: 32'h1, b: 32'h2, c: 32'h3, g: 0, d: 0, rdata: 32'hDEAD_BEEF, exp: 32'hDEAD_BEEF};
    vecs[2] = '{op: 7'h33, a: 32'hA5A5_0001, b: 32'h5A5A_0002, c: 32'hFFFF_0003, g: 10, d: 0, rdata: 32'h55, exp: 32'h55};
    vecs[3] = '{op: 7'h7F, a: 32'hFFFF_FFFF, b: 32'h8000_0000, c: 32'h1, g: 3, d: 5, rdata: 32'hFFFF_FFFF, exp: 32'hFFFF_FFFF};
    vecs[4] = '{op: 7'h40, a: 32'h0, b: 32'h0, c: 32'h0, g: 1, d: 1, rdata: 32'h0, exp: 32'h0};
    #12;
    chk("rst_req", dsp_req_o, 0);
    chk("rst_valid", result_valid_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_result", result_o, 0);
    chk("rst_a", dsp_a_o, 0);
    chk("rst_ready", ready_o, 1);
    @(negedge clk) rst = 0;
    tick;
    for (int i = 0; i < 5; i++) run(vecs[i]);
    // DONE holds without ex_ready, then back-to-back enable is not accepted in DONE
    start(7'h05, 32'h1, 32'h2, 32'h3);
    dsp_gnt_i = 1; dsp_rvalid_i = 1; dsp_rdata_i = 32'h77;
    tick;
    dsp_gnt_i = 0; dsp_rvalid_i = 0; dsp_rdata_i = 32'h0;
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", result_valid_o, 1);
      chk("hold_result", result_o, 32'h77);
      tick;
    end
    ex_ready_i = 1; enable_i = 1; operand_a_i = 32'hAA;
    tick;
    ex_ready_i = 0;
    chk("b2b_valid", result_valid_o, 0);
    chk("b2b_req", dsp_req_o, 0);
    chk("b2b_ready", ready_o, 0);
    chk("b2b_nocap", dsp_a_o, 32'h1);
    tick;
    enable_i = 0;
    chk("b2b_req2", dsp_req_o, 1);
    chk("b2b_cap", dsp_a_o, 32'hAA);
    dsp_gnt_i = 1; dsp_rvalid_i = 1; dsp_rdata_i = 32'h99;
    tick;
    dsp_gnt_i = 0; dsp_rvalid_i = 0;
    chk("b2b_result", result_o, 32'h99);
    flush_i = 1;
    tick;
    flush_i = 0;
    chk("done_flush_valid", result_valid_o, 0);
    chk("done_flush_ready", ready_o, 1);
    // flush in WAIT, response arrives three cycles later and is drained
    start(7'h06, 32'h10, 32'h20, 32'h30);
    dsp_gnt_i = 1;
    tick;
    dsp_gnt_i = 0; flush_i = 1;
    tick;
    flush_i = 0;
    for (int i = 0; i < 2; i++) begin
      chk("drain_valid", result_valid_o, 0);
      chk("drain_ready", ready_o, 0);
      chk("drain_a", dsp_a_o, 32'h10);
      tick;
    end
    dsp_rvalid_i = 1; dsp_rdata_i = 32'h1234;
    #1;
    chk("drain_rv_valid", result_valid_o, 0);
    tick;
    dsp_rvalid_i = 0;
    chk("drain_end_valid", result_valid_o, 0);
    chk("drain_end_err", err_o, 0);
    chk("drain_end_ready", ready_o, 1);
    chk("drain_end_result", result_o, 32'h99);
    // flush in REQ without grant, and with grant plus response
    start(7'h07, 32'h1, 32'h1, 32'h1);
    flush_i = 1;
    tick;
    flush_i = 0;
    chk("reqflush_req", dsp_req_o, 0);
    chk("reqflush_ready", ready_o, 1);
    start(7'h08, 32'h2, 32'h2, 32'h2);
    flush_i = 1; dsp_gnt_i = 1; dsp_rvalid_i = 1; dsp_rdata_i = 32'h5;
    tick;
    flush_i = 0; dsp_gnt_i = 0; dsp_rvalid_i = 0;
    chk("reqflush2_ready", ready_o, 1);
    chk("reqflush2_valid", result_valid_o, 0);
    chk("reqflush2_err", err_o, 0);
    chk("reqflush2_result", result_o, 32'h99);
    // spurious response in IDLE sets sticky error
    dsp_rvalid_i = 1; dsp_rdata_i = 32'hBAD;
    tick;
    dsp_rvalid_i = 0;
    chk("spur_err", err_o, 1);
    chk("spur_ready", ready_o, 1);
    chk("spur_req", dsp_req_o, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("spur_sticky", err_o, 1);
    end
    rst = 1;
    #1;
    chk("spur_rst_err", err_o, 0);
    @(negedge clk) rst = 0;
    tick;
    // reset in WAIT abandons op; late response is spurious
    start(7'h09, 32'hCAFE, 32'hF00D, 32'hBEEF);
    dsp_gnt_i = 1;
    tick;
    dsp_gnt_i = 0;
    chk("wait_req_low", dsp_req_o, 0);
    rst = 1;
    #1;
    chk("mrst_a", dsp_a_o, 0);
    chk("mrst_b", dsp_b_o, 0);
    chk("mrst_c", dsp_c_o, 0);
    chk("mrst_op", dsp_op_o, 0);
    chk("mrst_req", dsp_req_o, 0);
    chk("mrst_valid", result_valid_o, 0);
    chk("mrst_result", result_o, 0);
    chk("mrst_err", err_o, 0);
    @(negedge clk) rst = 0;
    tick;
    dsp_rvalid_i = 1; dsp_rdata_i = 32'h42;
    tick;
    dsp_rvalid_i = 0;
    chk("late_err", err_o, 1);
    chk("late_valid", result_valid_o, 0);
    chk("late_result", result_o, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
